// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared types and helpers for the Han-Carlson adder sum stages
//
// Contents:
//   HC_WIDTH     - default operand width the result struct is sized for
//   skid_state_t - occupancy of the 2-entry skid buffer (EMPTY, ONE, TWO)
//   hc_result_t  - packed {sum, cout, ovf} result of one addition
//   hc_calc()    - sum/cout/ovf from the propagate and group-generate vectors
package hc_pkg;

   localparam int HC_WIDTH = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic [HC_WIDTH-1:0] sum;
      logic                cout;
      logic                ovf;
   } hc_result_t;

   // p_hi is the propagate vector without its carry-in position (p[WIDTH:1]);
   // gi[i] is the carry into bit i, so the top two carries give signed overflow.
   function automatic hc_result_t hc_calc(input logic [HC_WIDTH-1:0] p_hi,
                                          input logic [HC_WIDTH:0]   gi);
      hc_result_t r;
      r.sum  = p_hi ^ gi[HC_WIDTH-1:0];
      r.cout = gi[HC_WIDTH];
      r.ovf  = gi[HC_WIDTH] ^ gi[HC_WIDTH-1];
      return r;
   endfunction

endpackage

// File: rtl/hc_skid_buf.sv
// rtl/hc_skid_buf.sv - generic 2-entry valid/ready skid buffer
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - upstream handshake; in_ready is a pure register output
//   in_data[DATA_W]      - payload captured on accept
//   out_valid/out_ready  - downstream handshake
//   out_data[DATA_W]     - payload from the main register (cleared on reset)
module hc_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   import hc_pkg::*;

   skid_state_t       state_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              accept;
   logic              deliver;

   assign accept    = in_valid & in_ready_q;
   assign deliver   = out_valid_q & out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

   // in_ready is tracked as its own flop (low only in TWO) so upstream never
   // sees a combinational path from out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_q      <= in_data;
                  out_valid_q <= 1'b1;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  main_q <= in_data;
               end else if (accept) begin
                  // Consumer stalled: park the newer item behind main.
                  skid_q     <= in_data;
                  in_ready_q <= 1'b0;
                  state_q    <= TWO;
               end else if (deliver) begin
                  out_valid_q <= 1'b0;
                  state_q     <= EMPTY;
               end
            end
            TWO: begin
               if (deliver) begin
                  main_q     <= skid_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hc_sum_stage.sv
// rtl/hc_sum_stage.sv - registered Han-Carlson sum stage with skid buffer and result counter
//
// Optional feature macro: HC_SUM_OVF_EN (adds ovf_out, signed overflow flag).
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input handshake for p_in/gi_in
//   p_in[WIDTH+1]        - bitwise propagate, bit 0 is the carry-in slot (unused)
//   gi_in[WIDTH+1]       - group generate, gi_in[i] = carry into bit i
//   out_valid/out_ready  - result handshake
//   sum_out[WIDTH]       - registered sum
//   cout_out             - registered carry-out
//   ovf_out              - registered signed overflow (HC_SUM_OVF_EN only)
//   res_cnt[CNT_W]       - saturating count of delivered results
module hc_sum_stage
   import hc_pkg::*;
#(
   parameter int WIDTH = HC_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   p_in,
   input  logic [WIDTH:0]   gi_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
`ifdef HC_SUM_OVF_EN
   output logic             ovf_out,
`endif
   output logic [CNT_W-1:0] res_cnt
);

`ifdef HC_SUM_OVF_EN
   localparam int PAY_W = WIDTH + 2;
`else
   localparam int PAY_W = WIDTH + 1;
`endif

   logic [WIDTH-1:0] sum_c;
   logic             cout_c;
   logic             ovf_c;
   logic [PAY_W-1:0] pay_in;
   logic [PAY_W-1:0] pay_out;
   logic [CNT_W-1:0] res_cnt_q;
   logic             unused_p0;

   // p_in[0] is always zero from the PG network and carries no information.
   assign unused_p0 = p_in[0];

   generate
      if (WIDTH == HC_WIDTH) begin : g_pkg_calc
         hc_result_t res_c;
         assign res_c  = hc_calc(p_in[WIDTH:1], gi_in);
         assign sum_c  = res_c.sum;
         assign cout_c = res_c.cout;
         assign ovf_c  = res_c.ovf;
      end else begin : g_inline_calc
         assign sum_c  = p_in[WIDTH:1] ^ gi_in[WIDTH-1:0];
         assign cout_c = gi_in[WIDTH];
         assign ovf_c  = gi_in[WIDTH] ^ gi_in[WIDTH-1];
      end
   endgenerate

`ifdef HC_SUM_OVF_EN
   assign pay_in  = {ovf_c, cout_c, sum_c};
   assign ovf_out = pay_out[WIDTH+1];
`else
   logic unused_ovf;
   assign unused_ovf = ovf_c;
   assign pay_in     = {cout_c, sum_c};
`endif

   assign sum_out  = pay_out[WIDTH-1:0];
   assign cout_out = pay_out[WIDTH];

   hc_skid_buf #(
      .DATA_W (PAY_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (pay_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (pay_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_cnt_q <= '0;
      end else if (out_valid && out_ready && (res_cnt_q != {CNT_W{1'b1}})) begin
         res_cnt_q <= res_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_hc_sum_stage.sv
// tb/tb_hc_sum_stage.sv - self-checking bench for hc_sum_stage (FIFO model + directed vectors)
module tb_hc_sum_stage;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W:0]   p_in = '0;
   logic [W:0]   gi_in = '0;

   logic         in_ready, out_valid, cout_out;
   logic [W-1:0] sum_out;
   logic [15:0]  res_cnt;
   logic         in_ready2, out_valid2, cout_out2;
   logic [W-1:0] sum_out2;
   logic [3:0]   res_cnt2;
`ifdef HC_SUM_OVF_EN
   logic         ovf_out, ovf_out2;
`endif

   hc_sum_stage #(.WIDTH(W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p_in(p_in), .gi_in(gi_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .cout_out(cout_out),
`ifdef HC_SUM_OVF_EN
      .ovf_out(ovf_out),
`endif
      .res_cnt(res_cnt)
   );

   hc_sum_stage #(.WIDTH(W), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .p_in(p_in), .gi_in(gi_in), .out_valid(out_valid2), .out_ready(out_ready),
      .sum_out(sum_out2), .cout_out(cout_out2),
`ifdef HC_SUM_OVF_EN
      .ovf_out(ovf_out2),
`endif
      .res_cnt(res_cnt2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected result {ovf, cout, sum} from plain integer addition.
   function automatic logic [17:0] expect_of(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin);
      logic [16:0] s;
      logic        ovf;
      s   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      ovf = (a[15] == b[15]) && (s[15] != a[15]);
      return {ovf, s};
   endfunction

   // Carries into each bit, as the PG network would present them.
   function automatic logic [16:0] mk_gi(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin);
      logic [16:0] g;
      logic        c;
      c = cin;
      for (int i = 0; i <= 16; i++) begin
         g[i] = c;
         if (i < 16) c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      end
      return g;
   endfunction

   logic [15:0] cur_a = '0, cur_b = '0;
   logic        cur_cin = 1'b0;

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic v);
      cur_a    = a;
      cur_b    = b;
      cur_cin  = cin;
      p_in     = {a ^ b, 1'b0};
      gi_in    = mk_gi(a, b, cin);
      in_valid = v;
   endtask

   task automatic idle_garbage();
      in_valid = 1'b0;
      p_in     = 17'($urandom);
      gi_in    = 17'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a 2-deep FIFO of expected results plus delivery count.
   logic [17:0] q[$];
   int          cnt = 0, acc_n = 0, del_n = 0;
   bit          model_ok = 1'b0;
   logic        m_dlv, m_acc;

   always @(negedge clk) begin
      if (model_ok && rst_n) begin
         check("in_ready", in_ready, q.size() < 2);
         check("out_valid", out_valid, q.size() > 0);
         check("res_cnt", res_cnt, cnt);
         check("res_cnt_sat", res_cnt2, (cnt > 15) ? 15 : cnt);
         check("in_ready_sat", in_ready2, q.size() < 2);
         check("out_valid_sat", out_valid2, q.size() > 0);
         if (q.size() > 0) begin
            check("sum", sum_out, q[0][15:0]);
            check("cout", cout_out, q[0][16]);
            check("sum_sat", sum_out2, q[0][15:0]);
`ifdef HC_SUM_OVF_EN
            check("ovf", ovf_out, q[0][17]);
`endif
         end
      end
      if (!rst_n) begin
         q.delete();
         cnt      = 0;
         acc_n    = 0;
         del_n    = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_dlv = (q.size() > 0) && out_ready;
         m_acc = in_valid && (q.size() < 2);
         if (m_dlv) begin
            void'(q.pop_front());
            cnt++;
            del_n++;
         end
         if (m_acc) begin
            q.push_back(expect_of(cur_a, cur_b, cur_cin));
            acc_n++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sum", sum_out, 0);
      check("rst_cout", cout_out, 0);
      check("rst_res_cnt", res_cnt, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // 0xFFFF + 0x0001: full carry ripple
      drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      step();
      check("t1_valid", out_valid, 1);
      check("t1_sum", sum_out, 16'h0000);
      check("t1_cout", cout_out, 1);
`ifdef HC_SUM_OVF_EN
      check("t1_ovf", ovf_out, 0);
`endif
      // 0x7FFF + 0x0001: signed overflow
      drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      step();
      check("t2_sum", sum_out, 16'h8000);
      check("t2_cout", cout_out, 0);
`ifdef HC_SUM_OVF_EN
      check("t2_ovf", ovf_out, 1);
`endif
      idle_garbage();
      step();
      check("t2_drained", out_valid, 0);
      repeat (2) begin
         idle_garbage();
         step();
      end

      // Backpressure: two accepted, third held off until space returns
      out_ready = 1'b0;
      drive(16'h1234, 16'h1111, 1'b0, 1'b1);
      step();
      drive(16'h00FF, 16'h0001, 1'b1, 1'b1);
      step();
      check("bp_in_ready_low", in_ready, 0);
      check("bp_sum_first", sum_out, 16'h2345);
      drive(16'hF000, 16'h1000, 1'b0, 1'b1);
      step();
      step();
      check("bp_still_full", in_ready, 0);
      check("bp_hold_sum", sum_out, 16'h2345);
      out_ready = 1'b1;
      step();
      check("bp_ready_back", in_ready, 1);
      check("bp_sum_second", sum_out, 16'h0101);
      step();
      check("bp_sum_third", sum_out, 16'h0000);
      check("bp_cout_third", cout_out, 1);
      idle_garbage();
      step();
      check("bp_empty", out_valid, 0);
      check("bp_res_cnt", res_cnt, 5);

      // Random valid/ready traffic, 1000 transfers from a clean count
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 20000 && del_n < 1000; c++) begin
         if (acc_n < 1000 && $urandom_range(0, 1) == 1)
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
         else
            idle_garbage();
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle_garbage();
      check("rand_transfers", del_n, 1000);
      check("rand_res_cnt", res_cnt, 1000);
      check("rand_res_cnt_sat", res_cnt2, 15);
      check("rand_empty", out_valid, 0);
      step();

      // Reset while both entries are occupied
      out_ready = 1'b0;
      drive(16'hAAAA, 16'h5555, 1'b0, 1'b1);
      step();
      drive(16'h0F0F, 16'h0F0F, 1'b0, 1'b1);
      step();
      check("rst2_full", in_ready, 0);
      drive(16'h1111, 16'h1111, 1'b0, 1'b1);
      rst_n = 1'b0;
      step();
      check("rst2_out_valid", out_valid, 0);
      check("rst2_in_ready", in_ready, 1);
      check("rst2_sum", sum_out, 0);
      check("rst2_cout", cout_out, 0);
      check("rst2_res_cnt", res_cnt, 0);
      check("rst2_res_cnt_sat", res_cnt2, 0);
      rst_n = 1'b1;
      idle_garbage();
      out_ready = 1'b1;
      repeat (3) step();
      check("rst2_no_ghost", out_valid, 0);
      check("rst2_cnt_after", res_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hc_sum_stage.md
Name: hc_sum_stage

Overview:
- Registered sum-generation stage directly downstream of the Han-Carlson group PG network.
- Consumes the bitwise propagate vector P[WIDTH:0] and the group generate vector Gi[WIDTH:0] produced by the network.
- Forms sum and carry-out, and presents them through a 2-entry valid/ready skid buffer so the adder pipeline can absorb consumer backpressure without a combinational ready path.

Parameters:
- WIDTH, 16, operand width; P/Gi vectors are WIDTH+1 bits, bit 0 is the carry-in position.
- CNT_W, 16, width of the saturating result counter.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- in_valid  input  1  P/Gi inputs valid this cycle.
- in_ready  output  1  stage can accept an input this cycle.
- p_in  input  WIDTH+1  bitwise propagate; p_in[i+1] = a[i]^b[i]; p_in[0] = 0.
- gi_in  input  WIDTH+1  group generate from the PG network; gi_in[i] = carry into bit i.
- out_valid  output  1  sum/cout hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum_out  output  WIDTH  registered sum.
- cout_out  output  1  registered carry-out.
- res_cnt  output  CNT_W  number of results delivered, saturating.

Behaviour:
- Arithmetic: sum[i] = p_in[i+1] ^ gi_in[i] for i = 0..WIDTH-1; cout = gi_in[WIDTH]. No width extension; p_in[0] is ignored.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register. in_ready = (state != TWO) and is a register output only, with no combinational path from out_ready.
- States:
  - EMPTY: out_valid=0. Accept → ONE, main <= new.
  - ONE: Accept & Deliver → ONE, main <= new. Accept & !Deliver → TWO, skid <= new. !Accept & Deliver → EMPTY. Otherwise hold.
  - TWO: in_ready=0, so in_valid is ignored. Deliver → ONE, main <= skid. Otherwise hold.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 result per cycle while out_ready=1.
- Ordering: strict FIFO; skid content never overtakes main.
- Outputs stay stable while out_valid=1 and out_ready=0.
- res_cnt increments on each Deliver and saturates at 2^CNT_W-1 (no wrap).
- Reset (rst_n=0 at a clk edge, including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1 on the following cycle, sum_out=0, cout_out=0, res_cnt=0.
  - Any buffered results are discarded.
  - Inputs presented in the reset cycle are not accepted.
- in_valid=0 with garbage data: no state change. Data is captured only on Accept.

Optional Feature:
- Macro: HC_SUM_OVF_EN.
- Defined:
  - Adds output port ovf_out (1 bit) = gi_in[WIDTH] ^ gi_in[WIDTH-1] (signed two's-complement overflow), captured and buffered alongside sum/cout with identical timing.
  - Reset value 0.
- Undefined: port absent, no storage for it. All other behaviour is identical.

Decomposition:
- Shared package hc_pkg:
  - skid state enum (EMPTY, ONE, TWO).
  - result struct {sum, cout, ovf} parameterised by WIDTH via localparam.
  - function for the sum/cout computation, reusable by other adder variants.
- One natural sub-module: hc_skid_buf, a generic 2-entry valid/ready skid buffer on a DATA_W payload.
- hc_sum_stage = combinational sum logic + hc_skid_buf + res_cnt.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 (bench model derives p_in/gi_in), out_ready=1 → next cycle out_valid=1, sum_out=0x0000, cout_out=1; ovf_out=0 if enabled.
- a=0x7FFF, b=0x0001, cin=0 → sum_out=0x8000, cout_out=0; ovf_out=1 if enabled.
- Stream 3 back-to-back inputs with out_ready=0 → 2 accepted, in_ready=0 after the second accept, the third held off. Raise out_ready → results emerge in order, and the third is accepted the cycle after in_ready returns to 1.
- Random valid/ready toggling over 1000 transfers → no loss, no duplication, order preserved, res_cnt=1000.
- Assert rst_n=0 while state=TWO → next cycle out_valid=0, in_ready=1, sum_out=0, res_cnt=0. Buffered results never appear.
- CNT_W=4, deliver 20 results → res_cnt saturates at 15.
